uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//  UART serial receiver: oversampled start-bit detection, mid-bit sampling, optional parity, stop check.
//  Consumes the 1-clk sample-tick pulse from the baud tick generator (OVERSAMPLE ticks per bit).
//  Delivers one parallel word per frame with a 1-clk done strobe and error flags to the host side.
// PARAMETERS
//  DBIT        8   data bits per frame, LSB first
//  OVERSAMPLE  16  s_tick pulses per bit period (even, >=4)
//  SB_TICK     16  s_tick pulses counted in stop state (16=1 stop, 24=1.5, 32=2)
//  PARITY_EN   0   1 = parity bit follows data
//  PARITY_ODD  0   1 = odd parity, 0 = even (ignored if PARITY_EN=0)
// PORTS
//  clk           in   1     system clock
//  reset         in   1     asynchronous, active-low
//  s_tick        in   1     sample tick, 1-clk pulse from baud tick generator
//  rx            in   1     serial line, idle high, asynchronous to clk
//  rx_data       out  DBIT  last received word
//  rx_done_tick  out  1     1-clk pulse: rx_data/frame_err/parity_err updated
//  rx_busy       out  1     high in any state other than IDLE
//  frame_err     out  1     stop bit of last frame sampled 0
//  parity_err    out  1     parity mismatch on last frame (0 if PARITY_EN=0)
// BEHAVIOUR
//  - reset low: state IDLE, all counters 0, rx_data=0, rx_done_tick=0, rx_busy=0, errs=0, sync FFs=1, armed=0.
//  - rx passes 2-FF synchronizer (reset to 1); FSM sees rx_s only; 2-clk input latency.
//  - armed flag: set when rx_s==1 in IDLE; cleared on entering START. A start is accepted only if armed.
//  - FSM advances only on clk edges with s_tick=1, except IDLE->START (any clk). s_tick stuck low = stall, no timeout.
//  - IDLE: armed && rx_s==0 -> START, s=0.
//  - START: per tick s++; at s==OVERSAMPLE/2-1: rx_s==0 -> DATA, s=0, n=0; rx_s==1 -> IDLE (glitch, no strobe).
//  - DATA: at s==OVERSAMPLE-1: shreg={rx_s,shreg[DBIT-1:1]}, s=0; n==DBIT-1 -> PARITY if PARITY_EN else STOP; else n++.
//  - PARITY: at s==OVERSAMPLE-1 capture bit; perr = (^shreg ^ bit ^ PARITY_ODD); s=0 -> STOP.
//  - STOP: at s==SB_TICK-1 sample rx_s; next clk: rx_data<=shreg, frame_err<=~rx_s, parity_err<=perr,
//    rx_done_tick=1 for exactly 1 clk; -> IDLE.
//  - s wraps only via explicit clears above; s width = clog2(max(OVERSAMPLE,SB_TICK)), n width = clog2(DBIT).
//  - rx_data/frame_err/parity_err hold until next rx_done_tick; never change mid-frame.
//  - Break (rx low continuously): one frame with data 0, frame_err=1; no further frame until rx_s seen high.
//  - Back-to-back: start edge directly after stop midpoint is accepted (armed set by high stop bit in IDLE).
//  - rx_busy combinational from state (state!=IDLE).
//  - reset mid-frame: immediate abort to reset values; partial word discarded, no strobe.
// STRUCTURE
//  - uart_pkg: state encodings (IDLE, START, DATA, PARITY, STOP), default OVERSAMPLE/DBIT constants,
//    clog2 function shared with tick generator and transmitter.
//  - sub-module sync_2ff (reset value 1) for rx; FSM, counters, shift register in uart_rx.
//  - 2-process FSM: registered state/s/n/shreg/outputs, combinational next-state.
// TESTING
//  - Defaults, s_tick every 4 clks, send 0xA5 8N1 -> one rx_done_tick, rx_data=0xA5, frame_err=0, parity_err=0.
//  - rx low for 5 ticks then high -> returns IDLE, rx_busy drops, no rx_done_tick, rx_data unchanged.
//  - rx held low 20 bit periods -> one strobe, rx_data=0x00, frame_err=1; no second strobe until rx high then new frame.
//  - PARITY_EN=1 even, send 0x07 with parity bit 0 -> parity_err=1; resend with parity 1 -> parity_err=0.
//  - reset low during data bit 3 -> all outputs 0 in same cycle; next clean frame 0x3C -> rx_data=0x3C.
//  - frames 0x55 then 0xAA with zero idle gap -> two strobes OVERSAMPLE*10 ticks apart, data 0x55 then 0xAA.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame constants
// and the width helpers also used by the tick generator and transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  localparam int DEFAULT_DBIT       = 8;
  localparam int DEFAULT_OVERSAMPLE = 16;
  localparam int DEFAULT_SB_TICK    = 16;

  // Bits needed to hold values 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    while ((1 << bits) < value) begin
      bits = bits + 1;
    end
    if (bits < 1) begin
      bits = 1;
    end
    return bits;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset
// to RESET_VAL so the synchronized line starts at its idle level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start detection, mid-bit sampling of data and
// optional parity, stop-bit check, one-clock done strobe with error flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT       = DEFAULT_DBIT,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int SB_TICK    = DEFAULT_SB_TICK,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] rx_data,
  output logic            rx_done_tick,
  output logic            rx_busy,
  output logic            frame_err,
  output logic            parity_err
);

  localparam int S_W = clog2(max2(OVERSAMPLE, SB_TICK));
  localparam int N_W = clog2(DBIT);

  localparam logic [S_W-1:0] S_MID  = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0] S_BIT  = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(DBIT - 1);
  localparam logic           ODD    = (PARITY_ODD != 0);

  logic rx_s;

  rx_state_t       state, state_n;
  logic [S_W-1:0]  s, s_n;
  logic [N_W-1:0]  n, n_n;
  logic [DBIT-1:0] shreg, shreg_n;
  logic            perr, perr_n;
  logic            armed, armed_n;
  logic [DBIT-1:0] data_n;
  logic            ferr_n;
  logic            perr_out_n;
  logic            done_n;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      s            <= '0;
      n            <= '0;
      shreg        <= '0;
      perr         <= 1'b0;
      armed        <= 1'b0;
      rx_data      <= '0;
      frame_err    <= 1'b0;
      parity_err   <= 1'b0;
      rx_done_tick <= 1'b0;
    end else begin
      state        <= state_n;
      s            <= s_n;
      n            <= n_n;
      shreg        <= shreg_n;
      perr         <= perr_n;
      armed        <= armed_n;
      rx_data      <= data_n;
      frame_err    <= ferr_n;
      parity_err   <= perr_out_n;
      rx_done_tick <= done_n;
    end
  end

  // Only IDLE reacts on every clock; all other states step on sample ticks.
  // A start needs a high line seen in IDLE first, so a held-low break line
  // yields exactly one frame until the line returns high.
  always_comb begin
    state_n    = state;
    s_n        = s;
    n_n        = n;
    shreg_n    = shreg;
    perr_n     = perr;
    armed_n    = armed;
    data_n     = rx_data;
    ferr_n     = frame_err;
    perr_out_n = parity_err;
    done_n     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (rx_s) begin
          armed_n = 1'b1;
        end else if (armed) begin
          state_n = ST_START;
          s_n     = '0;
          armed_n = 1'b0;
        end
      end

      ST_START: begin
        if (s_tick) begin
          if (s == S_MID) begin
            if (!rx_s) begin
              state_n = ST_DATA;
              s_n     = '0;
              n_n     = '0;
              perr_n  = 1'b0;
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            s_n = s + 1'b1;
          end
        end
      end

      ST_DATA: begin
        if (s_tick) begin
          if (s == S_BIT) begin
            shreg_n = {rx_s, shreg[DBIT-1:1]};
            s_n     = '0;
            if (n == N_LAST) begin
              state_n = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            end else begin
              n_n = n + 1'b1;
            end
          end else begin
            s_n = s + 1'b1;
          end
        end
      end

      ST_PARITY: begin
        if (s_tick) begin
          if (s == S_BIT) begin
            perr_n  = (^shreg) ^ rx_s ^ ODD;
            s_n     = '0;
            state_n = ST_STOP;
          end else begin
            s_n = s + 1'b1;
          end
        end
      end

      ST_STOP: begin
        if (s_tick) begin
          if (s == S_STOP) begin
            data_n     = shreg;
            ferr_n     = ~rx_s;
            perr_out_n = perr;
            done_n     = 1'b1;
            s_n        = '0;
            state_n    = ST_IDLE;
          end else begin
            s_n = s + 1'b1;
          end
        end
      end

      default: begin
        state_n = ST_IDLE;
        s_n     = '0;
      end
    endcase
  end

  assign rx_busy = (state != ST_IDLE);

endmodule
